// File: rtl/pcie_park_pkg.sv
// Shared types and constants for the PCIe lane parker: FSM states, PRBS7 shape, per-lane seed.
package pcie_park_pkg;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    IDLE   = 2'd1,
    PARKED = 2'd2
  } park_state_e;

  localparam int PRBS_W     = 7;
  localparam int PRBS_TAP_A = 6;
  localparam int PRBS_TAP_B = 5;

  // Lane index offset by one so no lane ever starts in the all-zero lock-up state.
  function automatic logic [PRBS_W-1:0] prbs_seed(input int lane);
    return PRBS_W'(lane + 1);
  endfunction

endpackage

// File: rtl/pcie_lane_parker_if.sv
// Pin-side bundle of the lane parker; loopback_en exists only when PCIE_PARK_LOOPBACK_EN is defined.
interface pcie_lane_parker_if #(
  parameter int LANES = 1
);

  logic             CLK_GATE;
  logic             clear_act;
  logic [LANES-1:0] rxp_in;
  logic [LANES-1:0] rxn_in;
  logic [LANES-1:0] txp_out;
  logic [LANES-1:0] txn_out;
  logic             parked;
  logic [LANES-1:0] rx_active;
`ifdef PCIE_PARK_LOOPBACK_EN
  logic             loopback_en;
`endif

  modport master (
`ifdef PCIE_PARK_LOOPBACK_EN
    output loopback_en,
`endif
    output CLK_GATE,
    output clear_act,
    output rxp_in,
    output rxn_in,
    input  txp_out,
    input  txn_out,
    input  parked,
    input  rx_active
  );

  modport slave (
`ifdef PCIE_PARK_LOOPBACK_EN
    input  loopback_en,
`endif
    input  CLK_GATE,
    input  clear_act,
    input  rxp_in,
    input  rxn_in,
    output txp_out,
    output txn_out,
    output parked,
    output rx_active
  );

endinterface

// File: rtl/pcie_park_lane.sv
// One parked lane: RX synchroniser and saturating edge counter, PRBS7 keep-alive, registered TX pair.
// TX follows the PRBS while parked (or synced RX when lb_en_i), otherwise holds electrical idle.
module pcie_park_lane
  import pcie_park_pkg::*;
#(
  parameter int LANE_IDX   = 0,
  parameter int CNT_W      = 8,
  parameter int ACT_THRESH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic park_i,
  input  logic gate_i,
  input  logic clear_i,
  input  logic lb_en_i,
  input  logic rxp_i,
  input  logic rxn_i,
  output logic txp_o,
  output logic txn_o,
  output logic rx_active_o
);

  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  THRESH  = CNT_W'(ACT_THRESH);
  localparam logic [PRBS_W-1:0] SEED    = prbs_seed(LANE_IDX);

  logic              rxp_s1_q, rxp_s2_q, rxp_prev_q;
  logic              rxn_s1_q, rxn_s2_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PRBS_W-1:0] prbs_q, prbs_d;
  logic              txp_q, txp_d;
  logic              txn_q, txn_d;
  logic              rx_edge;
  logic              prbs_bit;

  always_comb begin
    rx_edge  = rxp_s2_q ^ rxp_prev_q;
    prbs_bit = prbs_q[PRBS_TAP_A] ^ prbs_q[PRBS_TAP_B];

    // A clear on the same edge as a detected transition drops that transition.
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (rx_edge && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    prbs_d = prbs_q;
    txp_d  = txp_q;
    txn_d  = txn_q;
    if (!park_i) begin
      txp_d = 1'b0;
      txn_d = 1'b0;
    end else begin
      if (gate_i) begin
        prbs_d = {prbs_q[PRBS_W-2:0], prbs_bit};
      end
      if (lb_en_i) begin
        txp_d = rxp_s2_q;
        txn_d = rxn_s2_q;
      end else if (gate_i) begin
        txp_d = prbs_bit;
        txn_d = ~prbs_bit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxp_s1_q   <= 1'b0;
      rxp_s2_q   <= 1'b0;
      rxp_prev_q <= 1'b0;
      rxn_s1_q   <= 1'b0;
      rxn_s2_q   <= 1'b0;
      cnt_q      <= '0;
      prbs_q     <= SEED;
      txp_q      <= 1'b0;
      txn_q      <= 1'b0;
    end else begin
      rxp_s1_q   <= rxp_i;
      rxp_s2_q   <= rxp_s1_q;
      rxp_prev_q <= rxp_s2_q;
      rxn_s1_q   <= rxn_i;
      rxn_s2_q   <= rxn_s1_q;
      cnt_q      <= cnt_d;
      prbs_q     <= prbs_d;
      txp_q      <= txp_d;
      txn_q      <= txn_d;
    end
  end

  assign txp_o       = txp_q;
  assign txn_o       = txn_q;
  assign rx_active_o = (cnt_q >= THRESH);

endmodule

// File: rtl/pcie_lane_parker.sv
// Terminates unused PCIe lanes: HOLD -> IDLE -> PARKED sequencer driving one pcie_park_lane per lane.
// Optional PCIE_PARK_LOOPBACK_EN adds loopback_en (RX-to-TX echo while parked).
module pcie_lane_parker
  import pcie_park_pkg::*;
#(
  parameter int LANES           = 1,
  parameter int RST_HOLD_CYCLES = 16,
  parameter int IDLE_CYCLES     = 64,
  parameter int CNT_W           = 8,
  parameter int ACT_THRESH      = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  pcie_lane_parker_if.slave  bus
);

  localparam int PH_MAX = (RST_HOLD_CYCLES > IDLE_CYCLES) ? RST_HOLD_CYCLES : IDLE_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PH_W-1:0] HOLD_LAST = PH_W'(RST_HOLD_CYCLES - 1);
  localparam logic [PH_W-1:0] IDLE_LAST = PH_W'(IDLE_CYCLES - 1);

  park_state_e      state_q, state_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic             park_w;
  logic             lb_en_w;
  logic [LANES-1:0] txp_w, txn_w, act_w;

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    case (state_q)
      HOLD: begin
        if (ph_q == HOLD_LAST) begin
          state_d = IDLE;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      IDLE: begin
        if (ph_q == IDLE_LAST) begin
          state_d = PARKED;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      PARKED: begin
        state_d = PARKED;
      end
      default: begin
        state_d = HOLD;
        ph_d    = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= HOLD;
      ph_q    <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
    end
  end

  assign park_w = (state_q == PARKED);

`ifdef PCIE_PARK_LOOPBACK_EN
  assign lb_en_w = bus.loopback_en;
`else
  assign lb_en_w = 1'b0;
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pcie_park_lane #(
      .LANE_IDX   (i),
      .CNT_W      (CNT_W),
      .ACT_THRESH (ACT_THRESH)
    ) u_lane (
      .clk         (CLK),
      .rst_n       (RST_N),
      .park_i      (park_w),
      .gate_i      (bus.CLK_GATE),
      .clear_i     (bus.clear_act),
      .lb_en_i     (lb_en_w),
      .rxp_i       (bus.rxp_in[i]),
      .rxn_i       (bus.rxn_in[i]),
      .txp_o       (txp_w[i]),
      .txn_o       (txn_w[i]),
      .rx_active_o (act_w[i])
    );
  end

  assign bus.txp_out   = txp_w;
  assign bus.txn_out   = txn_w;
  assign bus.rx_active = act_w;
  assign bus.parked    = park_w;

endmodule

// File: tb/tb_pcie_lane_parker.sv
// Directed bench for pcie_lane_parker (LANES=2, CNT_W=3); loopback vectors run when PCIE_PARK_LOOPBACK_EN is defined.
module tb_pcie_lane_parker;
  import pcie_park_pkg::*;

  localparam int LANES  = 2;
  localparam int HOLD_N = 16;
  localparam int IDLE_N = 64;
  localparam int CNT_W  = 3;
  localparam int THR    = 4;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [6:0]       m [LANES];
  logic [LANES-1:0] last_e;
  logic [0:6]       first7;

  pcie_lane_parker_if #(.LANES(LANES)) bus();

  pcie_lane_parker #(
    .LANES           (LANES),
    .RST_HOLD_CYCLES (HOLD_N),
    .IDLE_CYCLES     (IDLE_N),
    .CNT_W           (CNT_W),
    .ACT_THRESH      (THR)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic seed_model();
    for (int l = 0; l < LANES; l++) m[l] = prbs_seed(l);
  endtask

  // Next PRBS bit per lane: b = s[6]^s[5], s shifts left taking b.
  task automatic prbs_next(output logic [LANES-1:0] e);
    logic b;
    for (int l = 0; l < LANES; l++) begin
      b    = m[l][6] ^ m[l][5];
      m[l] = {m[l][5:0], b};
      e[l] = b;
    end
  endtask

  task automatic run_startup(input string tag);
    for (int e = 1; e <= HOLD_N + IDLE_N; e++) begin
      tick();
      check(tag, {bus.parked, bus.txp_out, bus.txn_out}, {(e == HOLD_N + IDLE_N), 4'b0000});
    end
  endtask

  task automatic check_first7(input string tag);
    logic [LANES-1:0] e;
    seed_model();
    for (int k = 0; k < 7; k++) begin
      tick();
      prbs_next(e);
      last_e = e;
      check(tag, {bus.txp_out, bus.txn_out}, {e, ~e});
      check("prbs_lane0_const", bus.txp_out[0], first7[k]);
    end
  endtask

  task automatic toggle1();
    bus.rxp_in[1] = ~bus.rxp_in[1];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1);
  end

  initial begin
    logic [LANES-1:0] e;
    first7        = 7'b0000011;
    bus.CLK_GATE  = 1'b1;
    bus.clear_act = 1'b0;
    bus.rxp_in    = '0;
    bus.rxn_in    = '0;
`ifdef PCIE_PARK_LOOPBACK_EN
    bus.loopback_en = 1'b0;
`endif
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);

    check("rst_txp", bus.txp_out, 2'b00);
    check("rst_txn", bus.txn_out, 2'b00);
    check("rst_parked", bus.parked, 1'b0);
    check("rst_rx_active", bus.rx_active, 2'b00);

    // Startup sequence and first PRBS bits
    RST_N = 1'b1;
    run_startup("startup");
    check_first7("prbs_first7");

    // CLK_GATE low freezes TX and generator state
    bus.CLK_GATE = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("gate_hold", {bus.txp_out, bus.txn_out}, {last_e, ~last_e});
    end
    bus.CLK_GATE = 1'b1;
    for (int i = 0; i < 130; i++) begin
      tick();
      prbs_next(e);
      check("prbs_resume", {bus.txp_out, bus.txn_out}, {e, ~e});
    end

    // RX activity: threshold 4 after the 4th toggle, 3 edges of latency
    check("rx_quiet", bus.rx_active, 2'b00);
    for (int t = 1; t <= 3; t++) begin
      toggle1();
      repeat (4) tick();
    end
    check("rx_cnt3", bus.rx_active, 2'b00);
    toggle1();
    tick();
    check("rx_lat1", bus.rx_active, 2'b00);
    tick();
    check("rx_lat2", bus.rx_active, 2'b00);
    tick();
    check("rx_lat3", bus.rx_active, 2'b10);
    tick();
    for (int t = 5; t <= 20; t++) begin
      toggle1();
      repeat (4) tick();
      check("rx_saturate", bus.rx_active, 2'b10);
    end

    // Clear coincident with a detected edge drops that edge
    toggle1();
    tick();
    tick();
    bus.clear_act = 1'b1;
    tick();
    bus.clear_act = 1'b0;
    check("clr_coinc", bus.rx_active, 2'b00);
    tick();
    for (int t = 1; t <= 3; t++) begin
      toggle1();
      repeat (4) tick();
    end
    check("clr_cnt3", bus.rx_active, 2'b00);
    toggle1();
    repeat (2) tick();
    check("clr_cnt4_early", bus.rx_active, 2'b00);
    tick();
    check("clr_cnt4", bus.rx_active, 2'b10);

    // Asynchronous reset mid-PARKED
    check("pre_rst_parked", bus.parked, 1'b1);
    check("pre_rst_tx", |{bus.txp_out, bus.txn_out}, 1'b1);
    RST_N = 1'b0;
    #1;
    check("async_rst", {bus.parked, bus.txp_out, bus.txn_out, bus.rx_active}, 7'b0);
    bus.rxp_in = '0;
    repeat (2) tick();
    check("rst_held", {bus.parked, bus.txp_out, bus.txn_out, bus.rx_active}, 7'b0);
`ifdef PCIE_PARK_LOOPBACK_EN
    bus.loopback_en = 1'b1;
    bus.rxp_in      = 2'b11;
`endif
    RST_N = 1'b1;
    run_startup("restart");
    check("restart_rx", bus.rx_active, 2'b00);
`ifdef PCIE_PARK_LOOPBACK_EN
    bus.loopback_en = 1'b0;
`endif
    check_first7("prbs_restart");

`ifdef PCIE_PARK_LOOPBACK_EN
    // Loopback: pins to TX in 3 edges, regardless of CLK_GATE
    bus.rxp_in = 2'b00;
    bus.rxn_in = 2'b11;
    repeat (4) tick();
    bus.CLK_GATE    = 1'b0;
    bus.loopback_en = 1'b1;
    bus.rxp_in      = 2'b11;
    bus.rxn_in      = 2'b00;
    tick();
    check("lb_edge1", {bus.txp_out, bus.txn_out}, 4'b0011);
    tick();
    check("lb_edge2", {bus.txp_out, bus.txn_out}, 4'b0011);
    tick();
    check("lb_edge3", {bus.txp_out, bus.txn_out}, 4'b1100);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
